reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- 8 x 16-bit architectural register file with pending-write scoreboard, for the LCA processor datapath.
- Storage uses the team's active-low-write, sync-reset register convention.
- Decode/issue reads two operands and claims a destination; writeback writes results and releases claims.
- R7 is the program counter: dedicated PC output and a PC-update port.

Parameters:
WIDTH, 16, data width of each register
NREG, 8, number of registers (R7 = PC)
AW, 3, register address width (log2 NREG)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low; clears all state
rd_addr_a  input  AW  read port A address
rd_data_a  output  WIDTH  read port A data
rd_busy_a  output  1  operand A has an outstanding write
rd_addr_b  input  AW  read port B address
rd_data_b  output  WIDTH  read port B data
rd_busy_b  output  1  operand B has an outstanding write
claim_n  input  1  active-low; mark claim_addr pending
claim_addr  input  AW  destination being issued
wr_n  input  1  active-low writeback strobe
wr_addr  input  AW  writeback destination
wr_data  input  WIDTH  writeback data
pc_wr_n  input  1  active-low PC update (R7)
pc_in  input  WIDTH  next PC value
pc_out  output  WIDTH  current R7 contents, registered
stall  output  1  issue must hold
pending_cnt  output  AW+1  number of busy bits set

Behaviour:
- Reset (reset==0 at posedge):
  - all registers and busy bits cleared to 0.
  - rd_data_*, pc_out and pending_cnt then read 0; stall and rd_busy_* read 0.
  - Reset overrides any simultaneous wr_n, claim_n or pc_wr_n.
- Reads are combinational, 0-cycle latency, with write bypass:
  - if wr_n==0 and wr_addr==rd_addr_x, rd_data_x=wr_data; else rd_data_x=reg[rd_addr_x].
  - For address 7 the bypass also covers pc_wr_n: general writeback has priority, then pc_in, then stored value.
- Writes:
  - at posedge with wr_n==0, reg[wr_addr] <= wr_data.
  - At posedge with pc_wr_n==0, R7 <= pc_in, unless wr_n==0 and wr_addr==7 in the same cycle; then wr_data wins.
  - pc_out reflects R7 from the cycle after the write.
  - R0 is an ordinary register (not hardwired to zero).
- Busy logic:
  - rd_busy_x = busy[rd_addr_x] AND NOT (wr_n==0 AND wr_addr==rd_addr_x). A same-cycle writeback resolves the hazard.
  - stall = rd_busy_a OR rd_busy_b OR (claim_n==0 AND busy[claim_addr] AND NOT (wr_n==0 AND wr_addr==claim_addr)). The last term is the WAW hazard.
- Scoreboard update at posedge (reset==1):
  - writeback with wr_n==0 clears busy[wr_addr].
  - claim with claim_n==0 AND stall==0 sets busy[claim_addr]; a claim while stall==1 is ignored.
  - Claim and writeback to the same address in the same cycle: busy ends set (the new claim wins), and reg is written with wr_data.
  - Writeback to a non-busy register is legal: data written, busy unchanged.
  - pc_wr_n does not touch busy[7].
- pending_cnt:
  - registered popcount of busy, updated with busy (one-cycle view of next state).
  - Range 0..8; it never wraps because each bit is counted once.

Test Plan:
- Reset sequence: write 0x1234 to R3, then assert reset=0 for one cycle -> R3 reads 0x0000, pc_out=0, pending_cnt=0, stall=0.
- Write/read with bypass: wr_n=0, wr_addr=2, wr_data=0xBEEF, rd_addr_a=2 in the same cycle -> rd_data_a=0xBEEF combinationally; next cycle with wr_n=1 it still reads 0xBEEF.
- RAW hazard:
  - claim R5 (claim_n=0), next cycle rd_addr_b=5 -> rd_busy_b=1, stall=1.
  - Writeback R5=0x00A5 -> same cycle rd_busy_b=0, rd_data_b=0x00A5; next cycle busy cleared, pending_cnt=0.
- WAW and simultaneous events:
  - with R4 busy, claim R4 -> stall=1 and claim ignored (pending_cnt stays 1).
  - Then writeback R4 together with claim R4 -> stall=0, busy[4] stays 1, R4=wr_data.
- PC port: pc_wr_n=0, pc_in=0x0010 -> pc_out=0x0010 next cycle.
  - Then pc_wr_n=0 pc_in=0x0012 with wr_n=0 wr_addr=7 wr_data=0x0200 -> pc_out=0x0200.
- Fill scoreboard: claim R0..R7 on 8 consecutive cycles -> pending_cnt counts 1..8; any further claim stalls; reset mid-sequence returns pending_cnt to 0 next cycle.

Source files
------------

// File: rtl/reg_file_sb.sv
// 8 x 16-bit register file with a pending-write scoreboard, write bypass on
// both read ports, and a dedicated PC (R7) output and update port.
module reg_file_sb #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_busy_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_busy_b,
  input  logic             claim_n,
  input  logic [AW-1:0]    claim_addr,
  input  logic             wr_n,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pc_wr_n,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic             stall,
  output logic [AW:0]      pending_cnt
);

  localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_next;
  logic [AW:0]      busy_next_cnt;
  logic             hit_a, hit_b, hit_claim, waw;

  assign hit_a     = !wr_n && (wr_addr == rd_addr_a);
  assign hit_b     = !wr_n && (wr_addr == rd_addr_b);
  assign hit_claim = !wr_n && (wr_addr == claim_addr);

  // Writeback bypass first, then a pending PC update for R7, then storage.
  assign rd_data_a = hit_a ? wr_data :
                     ((rd_addr_a == PC_IDX) && !pc_wr_n) ? pc_in : regs[rd_addr_a];
  assign rd_data_b = hit_b ? wr_data :
                     ((rd_addr_b == PC_IDX) && !pc_wr_n) ? pc_in : regs[rd_addr_b];

  // A writeback landing this cycle resolves both RAW and WAW hazards.
  assign rd_busy_a = busy[rd_addr_a] && !hit_a;
  assign rd_busy_b = busy[rd_addr_b] && !hit_b;
  assign waw       = !claim_n && busy[claim_addr] && !hit_claim;
  assign stall     = rd_busy_a || rd_busy_b || waw;

  assign pc_out = regs[PC_IDX];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it holding its old value and infer a latch.
  always_comb begin
    busy_next     = busy;
    busy_next_cnt = '0;
    if (!wr_n)
      busy_next[wr_addr] = 1'b0;
    // Ordered after the clear so a same-cycle claim to the same address wins.
    if (!claim_n && !stall)
      busy_next[claim_addr] = 1'b1;
    for (int i = 0; i < NREG; i++)
      busy_next_cnt = busy_next_cnt + (AW+1)'(busy_next[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the register array is cleared on reset because software expects
      // every register (including R0 and the PC) to read zero afterwards.
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      busy        <= '0;
      pending_cnt <= '0;
    end else begin
      if (!pc_wr_n)
        regs[PC_IDX] <= pc_in;
      // Later assignment overrides the PC update when writeback also targets R7.
      if (!wr_n)
        regs[wr_addr] <= wr_data;
      busy        <= busy_next;
      pending_cnt <= busy_next_cnt;
    end
  end

endmodule
